fifo24_serializer: RTL and testbench
====================================

Name: fifo24_serializer

Overview:
- Read-side consumer for the 24-bit SRL16 FIFO.
- Pops one 24-bit word at a time through the FIFO's oe/ov handshake and shifts it out MSB-first on a serial link: sclk, sdo, and a frame sync fs.
- Feeds serial DAC/codec-style converters from the DSP datapath.
- Frames go out back-to-back, with no idle clocks, while data is available.

Parameters:
- CLKDIV, 4, clk cycles per sclk half-period (>=2). One bit lasts 2*CLKDIV clk.
- WIDTH, 24, word width. Must match the FIFO data width.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  stream enable; level-sensitive.
- fdi  input  24  FIFO read data (FIFO pdo); valid in the same cycle as fv.
- fv  input  1  FIFO output valid (FIFO ov = oe & ~empty); a pop occurs in this cycle.
- foe  output  1  FIFO output enable (drives FIFO oe).
- sclk  output  1  serial bit clock; idles low.
- sdo  output  1  serial data; changes on sclk falling edge, stable at rising edge.
- fs  output  1  frame sync; high during the MSB bit period only.
- busy  output  1  high while a word is being shifted.
- urun  output  1  one-clk pulse on a FIFO underrun during streaming.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. sclk=0, sdo=0, fs=0, busy=0, urun=0, shift register=0, bit counter=0, divider=CLKDIV-1. A word in flight is discarded and no FIFO pop occurs while rst=0.
- States:
  - IDLE: no word loaded.
  - SHIFT: word loaded; sclk running.
- foe is combinational from registered state and en only, never from fv, to avoid a loop through the FIFO's ov logic:
  - foe = en & (IDLE | (SHIFT & last_edge)).
  - last_edge = (bit counter==WIDTH-1) & (divider==0) & (sclk==1).
- IDLE, fv=1 (load):
  - shift register <= fdi; sdo <= fdi[WIDTH-1].
  - fs <= 1, busy <= 1, sclk <= 0.
  - divider <= CLKDIV-1, bit counter <= 0, state <= SHIFT.
- IDLE, fv=0: hold. Waiting in IDLE is not an underrun.
- SHIFT, each clk:
  - If divider != 0: divider decrements.
  - Else: divider <= CLKDIV-1 and sclk toggles.
  - Rising edge (sclk 0->1): no data change.
  - Falling edge (sclk 1->0), not last bit: shift left by one; sdo <= next bit; bit counter increments; fs <= 0.
- End of word (falling edge with bit counter==WIDTH-1):
  - fv=1: load the new word exactly as in IDLE and stay in SHIFT. This is gap-free; fs rises again for the new MSB.
  - fv=0 with en=1: state <= IDLE, sdo <= 0, fs <= 0, busy <= 0, urun pulses high for 1 clk.
  - en=0: foe=0, state <= IDLE, no urun.
- en deasserted mid-word: the current word completes in full; no further pops.
- en asserted in IDLE with FIFO empty: foe=1, fv=0, wait; no urun.
- Timing:
  - Word period = 2*WIDTH*CLKDIV clk; 192 clk at defaults.
  - fs high for the first 2*CLKDIV clk of each word.
  - Latency from fv in IDLE to sdo=MSB: 1 clk. First sclk rising edge comes CLKDIV clk after load.
- Exactly one FIFO pop per transmitted word. fdi is sampled only in the cycle fv=1.

Test Plan:
- Reset mid-word: drop rst during bit 10 -> sclk/sdo/fs/busy go 0 immediately (asynchronously). After release with en=1 and FIFO empty: foe=1, no urun.
- Single word 0xA5C3F0, CLKDIV=4, en=1 -> sampling sdo on each sclk rise gives 1010_0101_1100_0011_1111_0000. fs=1 for clk 1-8 after load. busy drops 192 clk after load. urun pulses once. Exactly 1 pop.
- Back-to-back 0x800001 then 0x7FFFFE -> second MSB driven on the same clk as the first word's final sclk fall; no extra clk gap; fs re-asserts; 2 pops; no urun.
- en dropped at bit 5 of word 1 with a second word queued -> word 1 completes, foe stays 0, the second word remains in the FIFO, no urun.
- FIFO full (15 words), en=1 -> 15 contiguous frames totaling 2880 clk. urun pulses once after word 15. Empty flag set at the final pop.
- CLKDIV=2 -> each sclk half-period is 2 clk, word period is 96 clk, and data is correct for the pattern 0xFFFFFF followed by 0x000000.

Source files
------------

// File: rtl/fifo24_serializer.sv
// Read-side consumer for the 24-bit FIFO: pops one word per frame and shifts it
// out MSB-first on sclk/sdo with a one-bit-wide frame sync, back-to-back while data lasts.
module fifo24_serializer #(
    parameter int CLKDIV = 4,
    parameter int WIDTH  = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] fdi,
    input  logic             fv,
    output logic             foe,
    output logic             sclk,
    output logic             sdo,
    output logic             fs,
    output logic             busy,
    output logic             urun
);

    localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int CW = $clog2(WIDTH);
    localparam logic [DW-1:0] DIV_MAX  = DW'(CLKDIV - 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic [DW-1:0]    div_q, div_d;
    logic             sclk_q, sclk_d;
    logic             fs_q, fs_d;
    logic             busy_q, busy_d;
    logic             urun_q, urun_d;
    logic             last_edge;
    logic             load;

    // The final falling edge of a word is the only point in SHIFT where a new word may be taken.
    assign last_edge = (state_q == SHIFT) && (bitcnt_q == LAST_BIT) && (div_q == '0) && sclk_q;

    // foe never looks at fv, so there is no combinational loop through the FIFO's ov logic.
    assign foe  = rst & en & ((state_q == IDLE) | last_edge);
    assign load = foe & fv;

    always_comb begin
        // NOTE: every _d takes its _q value first, so no path leaves one unassigned and no latch is inferred.
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        div_d    = div_q;
        sclk_d   = sclk_q;
        fs_d     = fs_q;
        busy_d   = busy_q;
        urun_d   = 1'b0;

        if (state_q == SHIFT) begin
            if (div_q != '0) begin
                div_d = div_q - 1'b1;
            end else begin
                div_d  = DIV_MAX;
                sclk_d = ~sclk_q;
                if (sclk_q) begin
                    if (bitcnt_q != LAST_BIT) begin
                        shreg_d  = shreg_q << 1;
                        bitcnt_d = bitcnt_q + 1'b1;
                        fs_d     = 1'b0;
                    end else begin
                        state_d  = IDLE;
                        shreg_d  = '0;
                        bitcnt_d = '0;
                        fs_d     = 1'b0;
                        busy_d   = 1'b0;
                        urun_d   = en;
                    end
                end
            end
        end

        // A load in SHIFT can only happen on last_edge, so it cleanly overrides the end-of-word path.
        if (load) begin
            state_d  = SHIFT;
            shreg_d  = fdi;
            bitcnt_d = '0;
            div_d    = DIV_MAX;
            sclk_d   = 1'b0;
            fs_d     = 1'b1;
            busy_d   = 1'b1;
            urun_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            div_q    <= DIV_MAX;
            sclk_q   <= 1'b0;
            fs_q     <= 1'b0;
            busy_q   <= 1'b0;
            urun_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            div_q    <= div_d;
            sclk_q   <= sclk_d;
            fs_q     <= fs_d;
            busy_q   <= busy_d;
            urun_q   <= urun_d;
        end
    end

    // sdo is the shift register MSB: loaded with fdi, advanced on falling sclk, cleared at underrun.
    assign sdo  = shreg_q[WIDTH-1];
    assign sclk = sclk_q;
    assign fs   = fs_q;
    assign busy = busy_q;
    assign urun = urun_q;

endmodule

// File: tb/tb_fifo24_serializer.sv
// Bench for fifo24_serializer: queue-based FIFO model feeding the DUT, a scoreboard
// of popped words checked by a serial-link monitor, plus waveform-timing checks.
module tb_fifo24_serializer;

    localparam int W    = 24;
    localparam int DIV  = 4;
    localparam int DIV2 = 2;
    localparam int WP   = 2 * W * DIV;
    localparam int WP2  = 2 * W * DIV2;
    localparam int BUDGET = 20000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en  = 1'b0;
    logic         fv  = 1'b0;
    logic [W-1:0] fdi = '0;
    logic         foe, sclk, sdo, fs, busy, urun;

    logic         en2  = 1'b0;
    logic         fv2  = 1'b0;
    logic [W-1:0] fdi2 = '0;
    logic         foe2, sclk2, sdo2, fs2, busy2, urun2;

    logic [W-1:0] fifo[$];
    logic [W-1:0] fifo2[$];
    logic [W-1:0] exp_q[$];
    int           load_cyc[$];
    int           load2_cyc[$];
    int           tick_n = 0;
    int           tick2_n = 0;
    int           pops = 0;
    int           errors = 0;
    int           checks = 0;
    int           urun_cnt = 0;
    int           words_out = 0;
    int           nbits = 0;
    logic         prev_sclk = 1'b0;
    logic [W-1:0] shift_w = '0;

    always #5 clk = ~clk;

    fifo24_serializer #(.CLKDIV(DIV), .WIDTH(W)) u_dut (
        .clk(clk), .rst(rst), .en(en), .fdi(fdi), .fv(fv), .foe(foe),
        .sclk(sclk), .sdo(sdo), .fs(fs), .busy(busy), .urun(urun)
    );

    fifo24_serializer #(.CLKDIV(DIV2), .WIDTH(W)) u_dut2 (
        .clk(clk), .rst(rst), .en(en2), .fdi(fdi2), .fv(fv2), .foe(foe2),
        .sclk(sclk2), .sdo(sdo2), .fs(fs2), .busy(busy2), .urun(urun2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    // One clock of the FIFO model: ov = oe & ~empty, popping at the edge where ov is high.
    task automatic tick();
        #1;
        fv = foe && (fifo.size() != 0);
        if (fv) fdi = fifo[0];
        else    fdi = 24'($urandom);
        @(posedge clk);
        tick_n++;
        if (fv) begin
            exp_q.push_back(fifo.pop_front());
            load_cyc.push_back(tick_n);
            pops++;
        end
        @(negedge clk);
        fv = 1'b0;
    endtask

    task automatic tick2();
        #1;
        fv2 = foe2 && (fifo2.size() != 0);
        if (fv2) fdi2 = fifo2[0];
        else     fdi2 = 24'($urandom);
        @(posedge clk);
        tick2_n++;
        if (fv2) begin
            void'(fifo2.pop_front());
            load2_cyc.push_back(tick2_n);
        end
        @(negedge clk);
        fv2 = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < BUDGET) begin
            tick();
            n++;
        end
        if (n >= BUDGET) check("idle_timeout", 64'(n), 64'(0));
    endtask

    // Serial-link monitor: assembles words from sdo at each sclk rise and scores them.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            nbits     = 0;
            prev_sclk = 1'b0;
        end else begin
            if (urun) urun_cnt++;
            if (sclk && !prev_sclk) begin
                check("fs_at_bit", 64'(fs), 64'(nbits == 0));
                shift_w = {shift_w[W-2:0], sdo};
                nbits++;
                if (nbits == W) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL word_unexpected: got 0x%0h, want no word", shift_w);
                    end else begin
                        check("word", 64'(shift_w), 64'(exp_q.pop_front()));
                    end
                    words_out++;
                    nbits = 0;
                end
            end
            prev_sclk = sclk;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int u0, p0, w0, n, k0, total;
        logic [W-1:0] wa, wb;
        logic [2*W-1:0] bits2;
        int nr;
        logic p2;

        // Reset held with en=1: everything quiet and no pop allowed.
        @(negedge clk);
        en = 1'b1;
        repeat (3) tick();
        check("rst_outputs", 64'({sclk, sdo, fs, busy, urun, foe}), 64'(0));
        check("rst_no_pop", 64'(pops), 64'(0));
        rst = 1'b1;
        #1;
        check("foe_idle_empty", 64'(foe), 64'(1));
        repeat (4) tick();

        // Single word: full waveform against the timing rules.
        u0 = urun_cnt; p0 = pops; w0 = words_out;
        wa = 24'hA5C3F0;
        fifo.push_back(wa);
        tick();
        check("t1_msb_latency", 64'(sdo), 64'(wa[W-1]));
        for (int k = 1; k <= WP + 2; k++) begin
            logic e_sclk, e_fs, e_busy, e_urun;
            e_sclk = (k <= WP) && ((((k - 1) / DIV) % 2) == 1);
            e_fs   = (k <= 2 * DIV);
            e_busy = (k <= WP);
            e_urun = (k == WP + 1);
            check("t1_wave", 64'({sclk, fs, busy, urun}), 64'({e_sclk, e_fs, e_busy, e_urun}));
            tick();
        end
        check("t1_urun", 64'(urun_cnt - u0), 64'(1));
        check("t1_pops", 64'(pops - p0), 64'(1));
        check("t1_words", 64'(words_out - w0), 64'(1));

        // Back-to-back words: no gap, fs re-asserts, en dropped during word 2 so no underrun.
        u0 = urun_cnt; p0 = pops;
        wa = 24'h800001; wb = 24'h7FFFFE;
        fifo.push_back(wa);
        fifo.push_back(wb);
        k0 = load_cyc.size();
        tick();
        repeat (WP - 1) tick();
        check("t2_last_bit", 64'({sclk, sdo, fs, busy}), 64'({1'b1, wa[0], 1'b0, 1'b1}));
        tick();
        check("t2_next_msb", 64'({sclk, sdo, fs, busy}), 64'({1'b0, wb[W-1], 1'b1, 1'b1}));
        check("t2_gap", 64'(load_cyc[k0 + 1] - load_cyc[k0]), 64'(WP));
        en = 1'b0;
        wait_idle(n);
        repeat (3) tick();
        check("t2_urun", 64'(urun_cnt - u0), 64'(0));
        check("t2_pops", 64'(pops - p0), 64'(2));

        // en dropped at bit 5 with a second word queued: word 1 completes, word 2 stays put.
        u0 = urun_cnt; p0 = pops;
        en = 1'b1;
        fifo.push_back(24'($urandom));
        fifo.push_back(24'($urandom));
        tick();
        repeat (5 * 2 * DIV) tick();
        en = 1'b0;
        wait_idle(n);
        repeat (5) tick();
        check("t3_pops", 64'(pops - p0), 64'(1));
        check("t3_left", 64'(fifo.size()), 64'(1));
        check("t3_foe", 64'(foe), 64'(0));
        check("t3_urun", 64'(urun_cnt - u0), 64'(0));
        en = 1'b1;
        tick();
        wait_idle(n);
        repeat (2) tick();
        check("t3_drain_urun", 64'(urun_cnt - u0), 64'(1));
        check("t3_drain_pops", 64'(pops - p0), 64'(2));

        // Reset during bit 10: outputs clear asynchronously, word discarded, no pop in reset.
        u0 = urun_cnt;
        fifo.push_back(24'hFFFFFF);
        tick();
        repeat (10 * 2 * DIV + 3) tick();
        check("t4_pre_rst", 64'({sdo, busy}), 64'(2'b11));
        rst = 1'b0;
        #1;
        check("t4_async_clear", 64'({sclk, sdo, fs, busy}), 64'(0));
        exp_q.delete();
        p0 = pops;
        repeat (3) tick();
        check("t4_rst_foe", 64'(foe), 64'(0));
        check("t4_rst_pops", 64'(pops - p0), 64'(0));
        rst = 1'b1;
        #1;
        check("t4_release_foe", 64'(foe), 64'(1));
        repeat (20) tick();
        check("t4_busy", 64'(busy), 64'(0));
        check("t4_urun", 64'(urun_cnt - u0), 64'(0));

        // Full FIFO of 15 random words: 15 contiguous frames, single underrun at the end.
        u0 = urun_cnt; p0 = pops;
        en = 1'b0;
        for (int i = 0; i < 15; i++) fifo.push_back(24'($urandom));
        repeat (2) tick();
        check("t5_no_pop_disabled", 64'(pops - p0), 64'(0));
        en = 1'b1;
        k0 = load_cyc.size();
        tick();
        wait_idle(n);
        repeat (2) tick();
        check("t5_total_clk", 64'(n), 64'(15 * WP));
        check("t5_span", 64'(load_cyc[k0 + 14] - load_cyc[k0]), 64'(14 * WP));
        check("t5_pops", 64'(pops - p0), 64'(15));
        check("t5_urun", 64'(urun_cnt - u0), 64'(1));

        // Random bursts: each burst streams gap-free and ends in exactly one underrun.
        u0 = urun_cnt; p0 = pops; total = 0;
        for (int b = 0; b < 4; b++) begin
            int len;
            len = int'($urandom_range(1, 4));
            for (int i = 0; i < len; i++) fifo.push_back(24'($urandom));
            total += len;
            tick();
            wait_idle(n);
            repeat (3) tick();
            check("t6_burst_clk", 64'(n), 64'(len * WP));
        end
        check("t6_pops", 64'(pops - p0), 64'(total));
        check("t6_urun", 64'(urun_cnt - u0), 64'(4));

        // CLKDIV=2 instance: 2-clk half-periods, 96-clk words, all-ones then all-zeros.
        wa = 24'hFFFFFF; wb = 24'h000000;
        fifo2.push_back(wa);
        fifo2.push_back(wb);
        en2 = 1'b1;
        tick2();
        bits2 = '0; nr = 0; p2 = 1'b0;
        for (int k = 1; k <= 2 * WP2 + 1; k++) begin
            logic e_sclk, e_fs, e_busy, e_urun;
            e_sclk = (k <= 2 * WP2) && ((((k - 1) / DIV2) % 2) == 1);
            e_fs   = (k <= 2 * DIV2) || (k > WP2 && k <= WP2 + 2 * DIV2);
            e_busy = (k <= 2 * WP2);
            e_urun = (k == 2 * WP2 + 1);
            check("t7_wave", 64'({sclk2, fs2, busy2, urun2}), 64'({e_sclk, e_fs, e_busy, e_urun}));
            if (sclk2 && !p2) begin
                bits2 = {bits2[2*W-2:0], sdo2};
                nr++;
            end
            p2 = sclk2;
            tick2();
        end
        check("t7_data", 64'(bits2), 64'({wa, wb}));
        check("t7_bits", 64'(nr), 64'(2 * W));
        check("t7_period", 64'(load2_cyc[1] - load2_cyc[0]), 64'(WP2));

        repeat (4) tick();
        check("sb_drained", 64'(exp_q.size()), 64'(0));
        check("sb_words", 64'(words_out), 64'(pops - 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
